mantis_rr_sched: RTL and testbench
==================================

Name: mantis_rr_sched

Overview:
- Two-requester round-robin scheduler that time-shares one Mantis tweakable block-cipher core (64-bit block, 64-bit tweak, 128-bit key, enc/dec select).
- Holds the shared 128-bit key register.
- Accepts one operation at a time over valid/ready, drives registered operands to the core, waits a fixed core latency, and returns the result tagged with the requester id.
- Sits between the client request ports and the core instance.

Parameters:
- LAT, 1: cycles from operand capture to result sampling. Minimum 1. Use 1 for a combinational core and 2 for an input/output-registered core.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_wr  in  1  write key_in into the key register.
- key_in  in  128  new key value.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_enc  in  1  1 = encrypt, 0 = decrypt.
- req0_t  in  64  tweak.
- req0_p  in  64  input block.
- req1_valid, req1_ready, req1_enc, req1_t, req1_p: same as requester 0.
- core_enc  out  1  registered enc select to the core.
- core_t  out  64  registered tweak to the core.
- core_k  out  128  registered key to the core.
- core_p  out  64  registered block to the core.
- core_c  in  64  core result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester id of the result.
- rsp_c  out  64  result block.
- busy  out  1  state is not IDLE.
- done_cnt  out  CNT_W  number of completed responses.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, key_reg=0, all core_* outputs=0, rsp_valid=0, rsp_id=0, rsp_c=0, last_id=1, done_cnt=0. Any in-flight operation is discarded and no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant: if exactly one reqX_valid is high, grant X. If both are high, grant the id not equal to last_id.
  - Ready: reqX_ready = (state==IDLE) & grant==X. It is combinational from valid and state and is never high for both requesters.
  - Handshake (valid&ready) at edge E0: capture core_enc/t/p from the granted requester, core_k <= key_reg (or key_in if key_wr is high the same cycle), rsp_id <= X, last_id <= X, load wait counter with LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, at that edge (E0+LAT): rsp_c <= core_c, rsp_valid <= 1, go to RESP.
  - core_* outputs hold stable throughout WAIT.
- RESP:
  - rsp_valid, rsp_id and rsp_c hold stable until rsp_ready=1.
  - At the edge with rsp_valid&rsp_ready: rsp_valid <= 0, done_cnt increments (wraps modulo 2^CNT_W), go to IDLE.
  - The next grant happens no earlier than the following cycle, so back-to-back throughput is one op per LAT+2 cycles.
- Latency: with rsp_ready held high, rsp_valid rises LAT cycles after the request handshake edge.
- key_wr:
  - Accepted in any state, and the key register updates at the edge.
  - An operation already captured keeps its captured core_k.
  - A simultaneous write and grant uses key_in (write-through).
- rsp_ready while rsp_valid=0 is ignored.
- Request valid dropping without a handshake has no effect.
- core_* keep their last values in IDLE; they are not zeroed.

Decomposition:
- Package mantis_sched_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Constants BLK_W=64, TWK_W=64, KEY_W=128.
- Sub-module rr_arb2: 2-input round-robin grant logic.
  - Inputs: v0, v1, last_id.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational.

Test Plan:
- Key and encrypt: rst for 2 cycles, then key_wr with key_in=0x92F09952C625E3E9D7A060F714C0292B. Send req0 enc=1, t=0xBA912E6F1055FED2, p=0x60E43457311936FD. Require core_k equal to that key, and rsp_c = core model output for those operands, rsp_id=0, with rsp_valid rising LAT cycles after the handshake.
- Fairness: req0 and req1 valid continuously with rsp_ready=1. Grants alternate 0,1,0,1 starting with req0. done_cnt=4 after four responses, and never both readys high.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP. rsp_c and rsp_id stay stable, both req_ready stay 0, then one handshake returns to IDLE.
- Key update mid-op: key_wr with a new key during WAIT. The current op's core_k is unchanged, and the next op uses the new key. A key_wr in the grant cycle yields core_k=key_in.
- Reset mid-op: assert rst during WAIT. No rsp_valid appears, busy=0, done_cnt=0, and the next request's grant goes to req0.
- LAT=2 build: rsp_valid rises exactly 2 cycles after the handshake. A decrypt (enc=0) of the earlier ciphertext returns p=0x60E43457311936FD.

Source files
------------

// File: rtl/mantis_sched_pkg.sv
// Shared types and widths for the Mantis round-robin scheduler.
package mantis_sched_pkg;

    localparam int unsigned BLK_W = 64;
    localparam int unsigned TWK_W = 64;
    localparam int unsigned KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: ties go to the requester that was not served last.
module rr_arb2 (
    input  logic v0,
    input  logic v1,
    input  logic last_id,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = v0 | v1;
        gnt_id    = 1'b0;
        if (v0 && v1) begin
            gnt_id = ~last_id;
        end else if (v1) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/mantis_rr_sched.sv
// Time-shares one Mantis cipher core between two requesters; owns the shared key register.
module mantis_rr_sched
    import mantis_sched_pkg::*;
#(
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_wr,
    input  logic [KEY_W-1:0]       key_in,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_enc,
    input  logic [TWK_W-1:0]       req0_t,
    input  logic [BLK_W-1:0]       req0_p,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_enc,
    input  logic [TWK_W-1:0]       req1_t,
    input  logic [BLK_W-1:0]       req1_p,
    output logic                   core_enc,
    output logic [TWK_W-1:0]       core_t,
    output logic [KEY_W-1:0]       core_k,
    output logic [BLK_W-1:0]       core_p,
    input  logic [BLK_W-1:0]       core_c,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [BLK_W-1:0]       rsp_c,
    output logic                   busy,
    output logic [CNT_W-1:0]       done_cnt
);

    localparam int unsigned WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t              r_state;
    logic [KEY_W-1:0]    r_key;
    logic                r_last_id;
    logic [WCNT_W-1:0]   r_wcnt;

    logic                w_gnt_valid;
    logic                w_gnt_id;
    logic                w_take;

    rr_arb2 u_arb (
        .v0        (req0_valid),
        .v1        (req1_valid),
        .last_id   (r_last_id),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    // A grant in IDLE is the handshake; ready is gated by the arbiter so only one side sees it.
    assign w_take     = (r_state == IDLE) && w_gnt_valid;
    assign req0_ready = w_take && !w_gnt_id;
    assign req1_ready = w_take &&  w_gnt_id;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_key     <= '0;
            r_last_id <= 1'b1;
            r_wcnt    <= '0;
            core_enc  <= 1'b0;
            core_t    <= '0;
            core_k    <= '0;
            core_p    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_c     <= '0;
            done_cnt  <= '0;
        end else begin
            if (key_wr) begin
                r_key <= key_in;
            end

            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        core_enc  <= w_gnt_id ? req1_enc : req0_enc;
                        core_t    <= w_gnt_id ? req1_t   : req0_t;
                        core_p    <= w_gnt_id ? req1_p   : req0_p;
                        // Write-through so a key written in the grant cycle is used immediately.
                        core_k    <= key_wr ? key_in : r_key;
                        rsp_id    <= w_gnt_id;
                        r_last_id <= w_gnt_id;
                        r_wcnt    <= WCNT_W'(LAT - 1);
                        r_state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (r_wcnt == '0) begin
                        rsp_c     <= core_c;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_wcnt <= r_wcnt - WCNT_W'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mantis_rr_sched.sv
// Scoreboard bench: a LAT=1 instance with a combinational core model and a LAT=2 instance with a registered one.
module tb_mantis_rr_sched;
    import mantis_sched_pkg::*;

    localparam int unsigned LAT1  = 1;
    localparam int unsigned LAT2  = 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [127:0] K1 = 128'h92F09952C625E3E9D7A060F714C0292B;
    localparam logic [127:0] K2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] K3 = 128'hA5A55A5A0F0FF0F01234432156788765;
    localparam logic [63:0]  T0 = 64'hBA912E6F1055FED2;
    localparam logic [63:0]  P0 = 64'h60E43457311936FD;
    localparam logic [63:0]  T1 = 64'h0011223344556677;
    localparam logic [63:0]  P1 = 64'h8899AABBCCDDEEFF;

    typedef struct {
        logic          id;
        logic [63:0]   c;
        logic [127:0]  k;
    } exp_t;

    // Stand-in cipher: invertible so a decrypt of an encrypt returns the plaintext.
    function automatic logic [63:0] core_f(input logic enc, input logic [63:0] t,
                                           input logic [127:0] k, input logic [63:0] x);
        logic [63:0] y;
        if (enc) begin
            y = x ^ t ^ k[63:0];
            return {y[50:0], y[63:51]} ^ k[127:64];
        end
        y = x ^ k[127:64];
        return {y[12:0], y[63:13]} ^ t ^ k[63:0];
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LAT=1 instance signals
    logic          rst, key_wr, rsp_ready;
    logic [127:0]  key_in;
    logic          req0_valid, req0_ready, req0_enc, req1_valid, req1_ready, req1_enc;
    logic [63:0]   req0_t, req0_p, req1_t, req1_p;
    logic          core_enc, rsp_valid, rsp_id, busy;
    logic [63:0]   core_t, core_p, core_c, rsp_c;
    logic [127:0]  core_k;
    logic [CNT_W-1:0] done_cnt;

    // LAT=2 instance signals
    logic          b_rst, b_key_wr, b_rsp_ready;
    logic [127:0]  b_key_in;
    logic          b_req0_valid, b_req0_ready, b_req0_enc, b_req1_ready;
    logic [63:0]   b_req0_t, b_req0_p;
    logic          b_core_enc, b_rsp_valid, b_rsp_id, b_busy;
    logic [63:0]   b_core_t, b_core_p, b_core_c, b_rsp_c;
    logic [127:0]  b_core_k;
    logic [CNT_W-1:0] b_done_cnt;

    assign core_c = core_f(core_enc, core_t, core_k, core_p);
    always_ff @(posedge clk) b_core_c <= core_f(b_core_enc, b_core_t, b_core_k, b_core_p);

    mantis_rr_sched #(.LAT(LAT1), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .key_wr(key_wr), .key_in(key_in),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_enc(req0_enc),
        .req0_t(req0_t), .req0_p(req0_p),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_enc(req1_enc),
        .req1_t(req1_t), .req1_p(req1_p),
        .core_enc(core_enc), .core_t(core_t), .core_k(core_k), .core_p(core_p),
        .core_c(core_c), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy), .done_cnt(done_cnt)
    );

    mantis_rr_sched #(.LAT(LAT2), .CNT_W(CNT_W)) u_dut2 (
        .clk(clk), .rst(b_rst), .key_wr(b_key_wr), .key_in(b_key_in),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_enc(b_req0_enc),
        .req0_t(b_req0_t), .req0_p(b_req0_p),
        .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_enc(1'b0),
        .req1_t(64'h0), .req1_p(64'h0),
        .core_enc(b_core_enc), .core_t(b_core_t), .core_k(b_core_k), .core_p(b_core_p),
        .core_c(b_core_c), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_id(b_rsp_id), .rsp_c(b_rsp_c), .busy(b_busy), .done_cnt(b_done_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1_e, m2_e;
    int   hs1 = 0, hs2 = 0;
    logic pv1 = 1'b0, pv2 = 1'b0;

    // Monitor for the LAT=1 instance: latency, exclusive ready, and scoreboard pop on accept.
    always @(negedge clk) begin
        if (rst) begin
            pv1 = 1'b0;
        end else begin
            chk("one_ready", 128'(req0_ready & req1_ready), 128'(0));
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) hs1 = cyc + 1;
            if (rsp_valid && !pv1) chk("latency1", 128'(cyc - hs1), 128'(LAT1));
            pv1 = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp1_unexpected actual=%0h required=none", rsp_c);
                end else begin
                    m1_e = q1.pop_front();
                    chk("rsp1_id", 128'(rsp_id), 128'(m1_e.id));
                    chk("rsp1_c",  128'(rsp_c),  128'(m1_e.c));
                    chk("core1_k", core_k, m1_e.k);
                end
            end
        end
    end

    // Monitor for the LAT=2 instance.
    always @(negedge clk) begin
        if (b_rst) begin
            pv2 = 1'b0;
        end else begin
            if (b_req0_valid && b_req0_ready) hs2 = cyc + 1;
            if (b_rsp_valid && !pv2) chk("latency2", 128'(cyc - hs2), 128'(LAT2));
            pv2 = b_rsp_valid;
            if (b_rsp_valid && b_rsp_ready) begin
                if (q2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp2_unexpected actual=%0h required=none", b_rsp_c);
                end else begin
                    m2_e = q2.pop_front();
                    chk("rsp2_id", 128'(b_rsp_id), 128'(m2_e.id));
                    chk("rsp2_c",  128'(b_rsp_c),  128'(m2_e.c));
                    chk("core2_k", b_core_k, m2_e.k);
                end
            end
        end
    end

    task automatic push1(input logic id, input logic [63:0] c, input logic [127:0] k);
        exp_t e;
        e.id = id;
        e.c  = c;
        e.k  = k;
        q1.push_back(e);
    endtask

    task automatic wait_hs1(input logic id);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("hs1_timeout");
        tick();
    endtask

    task automatic issue1(input logic id, input logic enc, input logic [63:0] t,
                          input logic [63:0] p, input logic [127:0] k, input bit push);
        if (push) push1(id, core_f(enc, t, k, p), k);
        if (id) begin
            req1_valid = 1'b1; req1_enc = enc; req1_t = t; req1_p = p;
        end else begin
            req0_valid = 1'b1; req0_enc = enc; req0_t = t; req0_p = p;
        end
        wait_hs1(id);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_idle1();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("idle1_timeout");
    endtask

    task automatic key1(input logic [127:0] k);
        key_wr = 1'b1;
        key_in = k;
        tick();
        key_wr = 1'b0;
    endtask

    task automatic issue2(input logic enc, input logic [63:0] t, input logic [63:0] p,
                          input logic [63:0] c_exp, input logic [127:0] k);
        exp_t e;
        bit ok = 1'b0;
        e.id = 1'b0;
        e.c  = c_exp;
        e.k  = k;
        q2.push_back(e);
        b_req0_valid = 1'b1; b_req0_enc = enc; b_req0_t = t; b_req0_p = p;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("hs2_timeout");
        tick();
        b_req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!b_busy && q2.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("idle2_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1; key_wr = 1'b0; key_in = '0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_enc = 1'b0; req0_t = '0; req0_p = '0;
        req1_valid = 1'b0; req1_enc = 1'b0; req1_t = '0; req1_p = '0;
        b_rst = 1'b1; b_key_wr = 1'b0; b_key_in = '0; b_rsp_ready = 1'b1;
        b_req0_valid = 1'b0; b_req0_enc = 1'b0; b_req0_t = '0; b_req0_p = '0;

        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_done_cnt",  128'(done_cnt),  128'(0));
        chk("rst_core_k",    core_k,          128'(0));
        chk("rst_core_tp",   {core_t, core_p}, 128'(0));
        chk("rst_rsp",       {63'(0), rsp_id, rsp_c}, 128'(0));
        tick();

        // Key load and first encrypt from requester 0
        key1(K1);
        issue1(1'b0, 1'b1, T0, P0, K1, 1'b1);
        wait_idle1();
        chk("done_after_first", 128'(done_cnt), 128'(1));

        // Fairness from a fresh reset: last_id=1 so requester 0 wins the first tie
        rst = 1'b1;
        tick();
        rst = 1'b0;
        key1(K1);
        push1(1'b0, core_f(1'b1, T0, K1, P0), K1);
        push1(1'b1, core_f(1'b0, T1, K1, P1), K1);
        push1(1'b0, core_f(1'b1, T0, K1, P0), K1);
        push1(1'b1, core_f(1'b0, T1, K1, P1), K1);
        req0_valid = 1'b1; req0_enc = 1'b1; req0_t = T0; req0_p = P0;
        req1_valid = 1'b1; req1_enc = 1'b0; req1_t = T1; req1_p = P1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done_cnt == CNT_W'(4)) begin
                ok = 1'b1;
                break;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!ok) fail_now("fair_timeout");
        chk("fair_done_cnt", 128'(done_cnt), 128'(4));
        wait_idle1();

        // Backpressure: response held for 10 cycles with requester 1 waiting
        rsp_ready = 1'b0;
        issue1(1'b0, 1'b1, T1, P0, K1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("bp_valid_timeout");
        tick();
        push1(1'b1, core_f(1'b1, T0, K1, P1), K1);
        req1_valid = 1'b1; req1_enc = 1'b1; req1_t = T0; req1_p = P1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 128'(rsp_valid), 128'(1));
            chk("bp_c",     128'(rsp_c),     128'(core_f(1'b1, T1, K1, P0)));
            chk("bp_id",    128'(rsp_id),    128'(0));
            chk("bp_ready", 128'({req0_ready, req1_ready}), 128'(0));
        end
        tick();
        rsp_ready = 1'b1;
        wait_hs1(1'b1);
        req1_valid = 1'b0;
        wait_idle1();
        chk("bp_done_cnt", 128'(done_cnt), 128'(6));

        // Key written during WAIT must not disturb the captured key
        issue1(1'b0, 1'b1, T0, P1, K1, 1'b1);
        key1(K2);
        wait_idle1();
        issue1(1'b1, 1'b0, T1, P0, K2, 1'b1);
        wait_idle1();
        key_wr = 1'b1;
        key_in = K3;
        issue1(1'b0, 1'b1, T1, P1, K3, 1'b1);
        key_wr = 1'b0;
        wait_idle1();

        // Reset during WAIT discards the op; key and arbitration history clear
        issue1(1'b0, 1'b1, T0, P0, K3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rm_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rm_busy",      128'(busy),      128'(0));
        chk("rm_done_cnt",  128'(done_cnt),  128'(0));
        tick();
        tick();
        push1(1'b0, core_f(1'b0, T1, 128'(0), P1), 128'(0));
        req0_valid = 1'b1; req0_enc = 1'b0; req0_t = T1; req0_p = P1;
        req1_valid = 1'b1; req1_enc = 1'b1; req1_t = T0; req1_p = P0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("rm_hs_timeout");
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle1();

        // LAT=2 instance: encrypt, then decrypt the ciphertext back to the plaintext
        b_rst = 1'b0;
        b_key_wr = 1'b1;
        b_key_in = K1;
        tick();
        b_key_wr = 1'b0;
        issue2(1'b1, T0, P0, core_f(1'b1, T0, K1, P0), K1);
        issue2(1'b0, T0, core_f(1'b1, T0, K1, P0), 64'h60E43457311936FD, K1);
        chk("lat2_done_cnt", 128'(b_done_cnt), 128'(2));

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
